// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing for the VGA pixel-timing source.
// Latency: n/a (types and constants only).
// Backpressure: none.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int COORD_RANGE   = 1024;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that re-times hs/vs to match registered pixel data.
// Latency: DEPTH cycles.
// Backpressure: none; advances every pixel clock.
module sync_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_sync,
    output logic [WIDTH-1:0] dly_sync
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= raw_sync;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dly_sync = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing source: DrawX/DrawY/blank, hs/vs and frame ticks; VGA_SYNC_DELAY_EN adds a hs/vs delay line.
// Latency: all outputs one cycle after the hc/vc counters (hs/vs PIPE_DEPTH more with VGA_SYNC_DELAY_EN).
// Backpressure: none; free-running on every pixel clock.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DEPTH = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_bad_totals
        $error("H_TOTAL and V_TOTAL must each be <= 1024");
    end
    if (PIPE_DEPTH < 1) begin : g_bad_pipe_depth
        $error("PIPE_DEPTH must be >= 1");
    end

    coord_t hc;
    coord_t vc;
    logic   h_wrap;
    logic   v_wrap;
    logic   wrap_q;
    logic   hs_raw;
    logic   vs_raw;

    assign h_wrap = (hc == H_LAST);
    assign v_wrap = (vc == V_LAST);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc           <= '0;
            vc           <= '0;
            wrap_q       <= 1'b0;
            DrawX        <= '0;
            DrawY        <= '0;
            blank        <= 1'b0;
            hs_raw       <= ~SYNC_POL;
            vs_raw       <= ~SYNC_POL;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            hc <= h_wrap ? '0 : hc + 1'b1;
            if (h_wrap) begin
                vc <= v_wrap ? '0 : vc + 1'b1;
            end

            DrawX        <= hc;
            DrawY        <= vc;
            blank        <= (hc < H_VIS) && (vc < V_VIS);
            hs_raw       <= (hc >= HS_FIRST && hc <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vs_raw       <= (vc >= VS_FIRST && vc <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            frame_start  <= (hc == '0) && (vc == '0);
            vblank_start <= (hc == '0) && (vc == V_VIS);

            // Count lands one cycle after the counter wrap so it shows up with frame_start;
            // the partial frame straight out of reset is never counted.
            wrap_q <= h_wrap && v_wrap;
            if (wrap_q) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] sync_dly;

    sync_delay_line #(
        .DEPTH   (PIPE_DEPTH),
        .WIDTH   (2),
        .RST_VAL ({~SYNC_POL, ~SYNC_POL})
    ) u_sync_dly (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .raw_sync ({hs_raw, vs_raw}),
        .dly_sync (sync_dly)
    );

    assign hs = sync_dly[1];
    assign vs = sync_dly[0];
`else
    assign hs = hs_raw;
    assign vs = vs_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line timing, small-geometry instance for frame-level behaviour.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int SYNC_LAT = 1;
`else
    localparam int SYNC_LAT = 0;
`endif

    // Small geometry: 24 x 15 = 360 clocks per frame
    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 2, SHT = 24;
    localparam int SVV = 8,  SVF = 2, SVS = 2, SVB = 3, SVT = 15;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [9:0]  d_x, d_y;
    logic        d_blank, d_hs, d_vs, d_fs, d_vb;
    logic [15:0] d_fc;

    logic [9:0]  s_x, s_y;
    logic        s_blank, s_hs, s_vs, s_fs, s_vb;
    logic [15:0] s_fc;

    int checks   = 0;
    int failures = 0;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen dut (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .DrawX        (d_x),
        .DrawY        (d_y),
        .blank        (d_blank),
        .hs           (d_hs),
        .vs           (d_vs),
        .frame_start  (d_fs),
        .vblank_start (d_vb),
        .frame_count  (d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .SYNC_POL  (1'b0), .PIPE_DEPTH (1)
    ) dut_s (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .DrawX        (s_x),
        .DrawY        (s_y),
        .blank        (s_blank),
        .hs           (s_hs),
        .vs           (s_vs),
        .frame_start  (s_fs),
        .vblank_start (s_vb),
        .frame_count  (s_fc)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Expected sync levels for the small instance at a sampled coordinate, accounting for sync delay.
    function automatic logic exp_vs_s(int x, int y);
        int p;
        int line;
        p = y * SHT + x - SYNC_LAT;
        if (p < 0) p += SHT * SVT;
        line = p / SHT;
        return (line >= SVV + SVF && line < SVV + SVF + SVS) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_hs_s(int x, int y);
        int p;
        int col;
        p = y * SHT + x - SYNC_LAT;
        if (p < 0) p += SHT * SVT;
        col = p % SHT;
        return (col >= SHV + SHF && col < SHV + SHF + SHS) ? 1'b0 : 1'b1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) tick();
        checks++; if (d_x !== 10'd0)      begin failures++; $display("FAIL reset_drawx got=%0d exp=0", d_x); end
        checks++; if (d_y !== 10'd0)      begin failures++; $display("FAIL reset_drawy got=%0d exp=0", d_y); end
        checks++; if (d_hs !== 1'b1)      begin failures++; $display("FAIL reset_hs got=%b exp=1", d_hs); end
        checks++; if (d_vs !== 1'b1)      begin failures++; $display("FAIL reset_vs got=%b exp=1", d_vs); end
        checks++; if (d_blank !== 1'b0)   begin failures++; $display("FAIL reset_blank got=%b exp=0", d_blank); end
        checks++; if (d_fc !== 16'd0)     begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", d_fc); end
        checks++; if (d_fs !== 1'b0 || d_vb !== 1'b0)
            begin failures++; $display("FAIL reset_pulses got fs=%b vb=%b exp=0/0", d_fs, d_vb); end
        reset_n = 1'b1;
        tick();
        checks++; if (d_blank !== 1'b1)   begin failures++; $display("FAIL first_edge_blank got=%b exp=1", d_blank); end
        checks++; if (d_fs !== 1'b1)      begin failures++; $display("FAIL first_edge_frame_start got=%b exp=1", d_fs); end
        checks++; if (d_x !== 10'd0 || d_y !== 10'd0)
            begin failures++; $display("FAIL first_edge_xy got=(%0d,%0d) exp=(0,0)", d_x, d_y); end
        checks++; if (d_fc !== 16'd0)     begin failures++; $display("FAIL first_edge_frame_count got=%0d exp=0", d_fc); end
        tick();
        checks++; if (d_x !== 10'd1 || d_fs !== 1'b0)
            begin failures++; $display("FAIL second_edge got x=%0d fs=%b exp x=1 fs=0", d_x, d_fs); end
    endtask

    task automatic test_line_timing();
        int n;
        int period, hs_cnt, hs_first, blank_cnt, vs_low;
        logic [9:0] y0;
        n = 0;
        while (d_x !== 10'd0 && n < 2000) begin tick(); n++; end
        checks++; if (d_x !== 10'd0) begin failures++; $display("FAIL line_align got x=%0d exp=0", d_x); end
        for (int line = 0; line < 2; line++) begin
            period = 0; hs_cnt = 0; hs_first = -1; blank_cnt = 0; vs_low = 0; y0 = d_y;
            do begin
                if (d_hs === 1'b0) begin
                    if (hs_first < 0) hs_first = int'(d_x);
                    hs_cnt++;
                end
                if (d_blank === 1'b1) blank_cnt++;
                if (d_vs === 1'b0) vs_low++;
                tick();
                period++;
            end while (d_x !== 10'd0 && period < 2000);
            checks++; if (period != 800)   begin failures++; $display("FAIL line%0d_period got=%0d exp=800", line, period); end
            checks++; if (hs_cnt != 96)    begin failures++; $display("FAIL line%0d_hs_width got=%0d exp=96", line, hs_cnt); end
            checks++; if (hs_first != 656 + SYNC_LAT)
                begin failures++; $display("FAIL line%0d_hs_start got=%0d exp=%0d", line, hs_first, 656 + SYNC_LAT); end
            checks++; if (blank_cnt != 640) begin failures++; $display("FAIL line%0d_blank_width got=%0d exp=640", line, blank_cnt); end
            checks++; if (vs_low != 0)     begin failures++; $display("FAIL line%0d_vs_low got=%0d exp=0", line, vs_low); end
            checks++; if (d_y !== y0 + 10'd1)
                begin failures++; $display("FAIL line%0d_drawy_step got=%0d exp=%0d", line, d_y, y0 + 10'd1); end
        end
    endtask

    task automatic test_frame_timing();
        int period, vb_cnt, vb_pos_err, vs_low, vs_err, hs_err, blank_err, late_blank;
        do_reset();
        checks++; if (s_fs !== 1'b1) begin failures++; $display("FAIL small_first_frame_start got=%b exp=1", s_fs); end
        period = 0; vb_cnt = 0; vb_pos_err = 0; vs_low = 0; vs_err = 0; hs_err = 0; blank_err = 0; late_blank = 0;
        do begin
            if (s_vb === 1'b1) begin
                vb_cnt++;
                if (s_x !== 10'd0 || s_y !== 10'(SVV)) vb_pos_err++;
            end
            if (s_vs === 1'b0) vs_low++;
            if (s_vs !== exp_vs_s(int'(s_x), int'(s_y))) vs_err++;
            if (s_hs !== exp_hs_s(int'(s_x), int'(s_y))) hs_err++;
            if (s_blank !== ((s_x < 10'(SHV)) && (s_y < 10'(SVV)))) blank_err++;
            if (s_y >= 10'(SVV) && s_blank === 1'b1) late_blank++;
            tick();
            period++;
        end while (s_fs !== 1'b1 && period < 2000);
        checks++; if (period != SHT * SVT) begin failures++; $display("FAIL frame_period got=%0d exp=%0d", period, SHT * SVT); end
        checks++; if (vb_cnt != 1)      begin failures++; $display("FAIL vblank_count got=%0d exp=1", vb_cnt); end
        checks++; if (vb_pos_err != 0)  begin failures++; $display("FAIL vblank_position got=%0d bad exp=0", vb_pos_err); end
        checks++; if (vs_low != SVS * SHT) begin failures++; $display("FAIL vs_low_cycles got=%0d exp=%0d", vs_low, SVS * SHT); end
        checks++; if (vs_err != 0)      begin failures++; $display("FAIL vs_placement got=%0d bad exp=0", vs_err); end
        checks++; if (hs_err != 0)      begin failures++; $display("FAIL hs_placement got=%0d bad exp=0", hs_err); end
        checks++; if (blank_err != 0)   begin failures++; $display("FAIL blank_decode got=%0d bad exp=0", blank_err); end
        checks++; if (late_blank != 0)  begin failures++; $display("FAIL blank_in_vblank got=%0d exp=0", late_blank); end
        checks++; if (s_fc !== 16'd1)   begin failures++; $display("FAIL frame1_count got=%0d exp=1", s_fc); end
    endtask

    task automatic test_frame_counter();
        int n;
        do_reset();
        checks++; if (s_fc !== 16'd0) begin failures++; $display("FAIL fc_start got=%0d exp=0", s_fc); end
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while (!(s_x == 10'(SHT - 1) && s_y == 10'(SVT - 1)) && n < 1000) begin tick(); n++; end
            checks++; if (s_fc !== 16'(k - 1))
                begin failures++; $display("FAIL fc_before_frame%0d got=%0d exp=%0d", k, s_fc, k - 1); end
            tick();
            checks++; if (s_fs !== 1'b1 || s_fc !== 16'(k))
                begin failures++; $display("FAIL fc_frame%0d got fs=%b fc=%0d exp fs=1 fc=%0d", k, s_fs, s_fc, k); end
        end
    endtask

    task automatic test_mid_frame_reset();
        int n, pulses;
        n = 0;
        while (!(s_x == 10'd10 && s_y == 10'd5) && n < 1000) begin tick(); n++; end
        checks++; if (s_x !== 10'd10 || s_y !== 10'd5)
            begin failures++; $display("FAIL midreset_reach got=(%0d,%0d) exp=(10,5)", s_x, s_y); end
        #5 reset_n = 1'b0;
        #1;
        checks++; if (s_x !== 10'd0 || s_y !== 10'd0 || d_x !== 10'd0)
            begin failures++; $display("FAIL midreset_xy got s=(%0d,%0d) d_x=%0d exp 0", s_x, s_y, d_x); end
        checks++; if (s_fc !== 16'd0)  begin failures++; $display("FAIL midreset_fc got=%0d exp=0", s_fc); end
        checks++; if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_blank !== 1'b0)
            begin failures++; $display("FAIL midreset_sync got hs=%b vs=%b blank=%b exp 1/1/0", s_hs, s_vs, s_blank); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (s_fs !== 1'b0 || s_vb !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
        reset_n = 1'b1;
        tick();
        checks++; if (s_fs !== 1'b1 || s_x !== 10'd0 || s_y !== 10'd0 || s_fc !== 16'd0)
            begin failures++; $display("FAIL midreset_restart got fs=%b xy=(%0d,%0d) fc=%0d exp 1,(0,0),0", s_fs, s_x, s_y, s_fc); end
        tick();
        checks++; if (s_x !== 10'd1 || s_fs !== 1'b0)
            begin failures++; $display("FAIL midreset_advance got x=%0d fs=%b exp x=1 fs=0", s_x, s_fs); end
    endtask

    task automatic test_frame_wrap();
        int n;
        force dut_s.frame_count = 16'hFFFF;
        tick();
        release dut_s.frame_count;
        tick();
        checks++; if (s_fc !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%0h exp=ffff", s_fc); end
        n = 0;
        while (!(s_x == 10'(SHT - 1) && s_y == 10'(SVT - 1)) && n < 1000) begin tick(); n++; end
        checks++; if (s_fc !== 16'hFFFF) begin failures++; $display("FAIL wrap_hold got=%0h exp=ffff", s_fc); end
        tick();
        checks++; if (s_fs !== 1'b1 || s_fc !== 16'h0000)
            begin failures++; $display("FAIL wrap_result got fs=%b fc=%0h exp fs=1 fc=0", s_fs, s_fc); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_frame_counter();
        test_mid_frame_reset();
        test_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
